// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into MIPS R/I/J words and writes them to sequential memory locations
module instr_encoder #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_kind,
   input  logic [4:0]            in_rs,
   input  logic [4:0]            in_rt,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_shamt,
   input  logic [5:0]            in_funct,
   input  logic [15:0]           in_imm,
   input  logic [25:0]           in_target,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  full,
   output logic                  err_illegal
);
   typedef enum logic {IDLE, WRITE} state_t;
   state_t state;
   logic legal;
   logic [31:0] encWord;
   logic [ADDR_WIDTH:0] cntNext;
   assign in_ready = (state == IDLE) && !full && !start;
   assign cntNext = word_count + (ADDR_WIDTH+1)'(1);
   // map the instruction kind onto its opcode and field layout; kinds 12-15 are flagged illegal
   always_comb begin
      legal = 1'b1;
      encWord = 32'h0;
      case (in_kind)
         4'd0:  encWord = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
         4'd1:  encWord = {6'h00, in_rs, 15'b0, 6'h08};
         4'd2:  encWord = {6'h08, in_rs, in_rt, in_imm};
         4'd3:  encWord = {6'h0d, in_rs, in_rt, in_imm};
         4'd4:  encWord = {6'h0f, 5'b0, in_rt, in_imm};
         4'd5:  encWord = {6'h0c, in_rs, in_rt, in_imm};
         4'd6:  encWord = {6'h23, in_rs, in_rt, in_imm};
         4'd7:  encWord = {6'h2b, in_rs, in_rt, in_imm};
         4'd8:  encWord = {6'h04, in_rs, in_rt, in_imm};
         4'd9:  encWord = {6'h05, in_rs, in_rt, in_imm};
         4'd10: encWord = {6'h02, in_target};
         4'd11: encWord = {6'h03, in_target};
         default: legal = 1'b0;
      endcase
   end
   // accept in IDLE, hold the write in WRITE until memory takes it, then advance address and count
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         word_count <= '0;
         full <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mem_addr <= '0;
                  word_count <= '0;
                  full <= 1'b0;
                  err_illegal <= 1'b0;
               end else if (in_valid && in_ready) begin
                  if (legal) begin
                     mem_wdata <= encWord;
                     mem_we <= 1'b1;
                     state <= WRITE;
                  end else begin
                     err_illegal <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  mem_we <= 1'b0;
                  mem_addr <= mem_addr + ADDR_WIDTH'(1);
                  word_count <= cntNext;
                  full <= cntNext == {1'b1, {ADDR_WIDTH{1'b0}}};
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed words for instr_encoder at ADDR_WIDTH=2
module tb_instr_encoder;
   logic clk = 0, reset = 1, start = 0, inValid = 0, memReady = 1;
   logic inReady, memWe, full, errIllegal;
   logic [3:0] inKind = 0;
   logic [4:0] inRs = 0, inRt = 0, inRd = 0, inShamt = 0;
   logic [5:0] inFunct = 0;
   logic [15:0] inImm = 0;
   logic [25:0] inTarget = 0;
   logic [1:0] memAddr;
   logic [31:0] memWdata;
   logic [2:0] wordCount;
   int checks = 0, failures = 0;

   instr_encoder #(.ADDR_WIDTH(2)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(inValid), .in_ready(inReady),
      .in_kind(inKind), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
      .in_funct(inFunct), .in_imm(inImm), .in_target(inTarget), .mem_we(memWe),
      .mem_addr(memAddr), .mem_wdata(memWdata), .mem_ready(memReady),
      .word_count(wordCount), .full(full), .err_illegal(errIllegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic setFields(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            input logic [15:0] im, input logic [25:0] tg);
      inKind = k; inRs = rs; inRt = rt; inRd = rd; inShamt = sh; inFunct = fn; inImm = im; inTarget = tg;
   endtask

   task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] im, input logic [25:0] tg);
      setFields(k, rs, rt, rd, sh, fn, im, tg);
      inValid = 1;
      tick();
      inValid = 0;
   endtask

   task automatic expectWrite(input string tag, input logic [1:0] addr, input logic [31:0] data);
      check({tag, "_we"}, 32'(memWe), 1);
      check({tag, "_addr"}, 32'(memAddr), 32'(addr));
      check({tag, "_data"}, memWdata, data);
      check({tag, "_rdy"}, 32'(inReady), 0);
      tick();
      check({tag, "_done"}, 32'(memWe), 0);
   endtask

   task automatic pulseStart();
      start = 1;
      tick();
      start = 0;
   endtask

   initial begin
      tick(); tick();
      reset = 0;
      tick();
      check("rst_we", 32'(memWe), 0);
      check("rst_addr", 32'(memAddr), 0);
      check("rst_data", memWdata, 0);
      check("rst_cnt", 32'(wordCount), 0);
      check("rst_full", 32'(full), 0);
      check("rst_err", 32'(errIllegal), 0);
      check("rst_rdy", 32'(inReady), 1);
      send(4'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
      expectWrite("addi", 2'd0, 32'h21280005);
      check("addi_cnt", 32'(wordCount), 1);
      check("addi_addr", 32'(memAddr), 1);
      check("addi_rdy", 32'(inReady), 1);
      pulseStart();
      check("start_cnt", 32'(wordCount), 0);
      check("start_addr", 32'(memAddr), 0);
      send(4'd0, 5'd9, 5'd8, 5'd10, 5'd0, 6'h20, 16'hffff, 26'd0);
      expectWrite("ralu", 2'd0, 32'h01285020);
      send(4'd1, 5'd31, 5'd7, 5'd6, 5'd5, 6'h3f, 16'd0, 26'd0);
      expectWrite("jr", 2'd1, 32'h03E00008);
      send(4'd11, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd0, 26'h0100000);
      expectWrite("jal", 2'd2, 32'h0C100000);
      send(4'd4, 5'd7, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1001, 26'd0);
      expectWrite("lui", 2'd3, 32'h3C011001);
      check("full_flag", 32'(full), 1);
      check("full_cnt", 32'(wordCount), 4);
      check("full_addr", 32'(memAddr), 0);
      setFields(4'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
      inValid = 1;
      check("full_rdy", 32'(inReady), 0);
      tick(); tick();
      check("full_nowe", 32'(memWe), 0);
      check("full_cnt2", 32'(wordCount), 4);
      start = 1;
      tick();
      check("sw_we", 32'(memWe), 0);
      check("sw_full", 32'(full), 0);
      check("sw_cnt", 32'(wordCount), 0);
      start = 0;
      tick();
      inValid = 0;
      expectWrite("after_start", 2'd0, 32'h21280005);
      memReady = 0;
      send(4'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
      for (int i = 0; i < 3; i++) begin
         check("stall_we", 32'(memWe), 1);
         check("stall_addr", 32'(memAddr), 1);
         check("stall_data", memWdata, 32'h21281234);
         check("stall_rdy", 32'(inReady), 0);
         tick();
      end
      memReady = 1;
      expectWrite("stall_end", 2'd1, 32'h21281234);
      check("stall_addr_inc", 32'(memAddr), 2);
      check("stall_cnt", 32'(wordCount), 2);
      send(4'd13, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1);
      check("ill_we", 32'(memWe), 0);
      check("ill_err", 32'(errIllegal), 1);
      check("ill_cnt", 32'(wordCount), 2);
      check("ill_rdy", 32'(inReady), 1);
      send(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00ff, 26'd0);
      expectWrite("ori", 2'd2, 32'h342200FF);
      send(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF);
      expectWrite("j", 2'd3, 32'h0BFFFFFF);
      check("ill_err_sticky", 32'(errIllegal), 1);
      check("j_full", 32'(full), 1);
      pulseStart();
      check("clr_err", 32'(errIllegal), 0);
      check("clr_full", 32'(full), 0);
      memReady = 0;
      send(4'd9, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hfffe, 26'd0);
      check("bne_we", 32'(memWe), 1);
      check("bne_data", memWdata, 32'h1464FFFE);
      reset = 1;
      tick();
      reset = 0;
      memReady = 1;
      check("midrst_we", 32'(memWe), 0);
      check("midrst_addr", 32'(memAddr), 0);
      check("midrst_data", memWdata, 0);
      check("midrst_cnt", 32'(wordCount), 0);
      tick();
      check("midrst_rdy", 32'(inReady), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
